// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed hex digit scan controller with frame-aligned double buffering
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits)

module hex_display_scanner #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dots,
   input  logic                load,
   output logic [3:0]          digit_in,
   output logic                dot_out,
   output logic [DIGITS-1:0]   an,
   output logic                frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SCAN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       index_q, index_d;
   logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
   logic [DIGITS-1:0]   disp_dots_q, disp_dots_d;
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   pend_dots_q, pend_dots_d;
   logic                pend_flag_q, pend_flag_d;
   logic                frame_end_q, frame_end_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [3:0]          digit_q, digit_d;
   logic                dot_q, dot_d;
   logic                frame_done_q, frame_done_d;

   logic tick;
   logic boundary;

   assign tick     = (state_q == ST_SCAN) && (presc_q == PRESC_LAST);
   assign boundary = tick && (index_q == INDEX_LAST);

   // Scan FSM: one blank cycle between digits, REFRESH_DIV cycles lit per digit
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      index_d = index_q;
      case (state_q)
         ST_BLANK: begin
            state_d = ST_SCAN;
            presc_d = '0;
         end
         ST_SCAN: begin
            if (tick) begin
               state_d = ST_BLANK;
               presc_d = '0;
               index_d = (index_q == INDEX_LAST) ? '0 : index_q + 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // Double buffer: pending captures every load, display only changes at the frame boundary
   always_comb begin
      disp_val_d  = disp_val_q;
      disp_dots_d = disp_dots_q;
      pend_val_d  = pend_val_q;
      pend_dots_d = pend_dots_q;
      pend_flag_d = pend_flag_q;
      frame_end_d = boundary;
      if (boundary && pend_flag_q) begin
         // Transfer takes the old pending contents even if a load lands on this same cycle
         disp_val_d  = pend_val_q;
         disp_dots_d = pend_dots_q;
         pend_flag_d = 1'b0;
      end
      if (load) begin
         pend_val_d  = value;
         pend_dots_d = dots;
         pend_flag_d = 1'b1;
      end
   end

   // Output decode from the current state; registered so outputs trail the state by one cycle
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      logic [4*DIGITS-1:0] upper;
`endif
      an_d         = '1;
      digit_d      = digit_q;
      dot_d        = dot_q;
      frame_done_d = 1'b0;
      if (state_q == ST_SCAN) begin
         an_d    = ~(DIGITS'(1) << index_q);
         digit_d = disp_val_q[{index_q, 2'b00} +: 4];
         dot_d   = disp_dots_q[index_q];
`ifdef LEADING_ZERO_BLANK_EN
         // Digit k stays dark when it and every more significant nibble are zero and it has no dot
         upper = disp_val_q >> {index_q, 2'b00};
         if ((index_q != '0) && (upper == '0) && !disp_dots_q[index_q]) begin
            an_d = '1;
         end
`endif
      end else begin
         // frame_end_q is high exactly during the blank cycle that follows the last digit
         frame_done_d = frame_end_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BLANK;
         presc_q      <= '0;
         index_q      <= '0;
         disp_val_q   <= '0;
         disp_dots_q  <= '0;
         pend_val_q   <= '0;
         pend_dots_q  <= '0;
         pend_flag_q  <= 1'b0;
         frame_end_q  <= 1'b0;
         an_q         <= '1;
         digit_q      <= '0;
         dot_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         index_q      <= index_d;
         disp_val_q   <= disp_val_d;
         disp_dots_q  <= disp_dots_d;
         pend_val_q   <= pend_val_d;
         pend_dots_q  <= pend_dots_d;
         pend_flag_q  <= pend_flag_d;
         frame_end_q  <= frame_end_d;
         an_q         <= an_d;
         digit_q      <= digit_d;
         dot_q        <= dot_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign digit_in   = digit_q;
   assign dot_out    = dot_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - scoreboard testbench for hex_display_scanner

module tb_hex_display_scanner;

   localparam int D  = 4;
   localparam int R  = 4;
   localparam int R1 = R + 1;
   localparam int FRAME = D * R1;

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dots;
   logic        load;
   logic [3:0]  digit_in;
   logic        dot_out;
   logic [3:0]  an;
   logic        frame_done;

   hex_display_scanner #(.DIGITS(D), .REFRESH_DIV(R)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dots       (dots),
      .load       (load),
      .digit_in   (digit_in),
      .dot_out    (dot_out),
      .an         (an),
      .frame_done (frame_done)
   );

   typedef struct {
      int          m;
      logic [15:0] v;
      logic [3:0]  d;
   } load_t;

   typedef struct {
      logic [3:0] an;
      logic [3:0] dig;
      logic       dot;
      logic       fd;
      bit         chk_data;
      int         m;
   } exp_t;

   load_t loads[$];
   exp_t  sbq[$];
   int    m;
   int    n_checks;
   int    n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: state cycle mm is blank when mm mod (R+1) == 0, else digit (mm/(R+1)) mod D.
   // Frame F shows the last value loaded strictly before the final tick of frame F-1.
   function automatic exp_t model(input int mm);
      exp_t        e;
      int          pos, slot, k, f, bound;
      logic [15:0] val;
      logic [3:0]  dt;
      logic [15:0] up;
      pos  = mm % R1;
      slot = mm / R1;
      e.m  = mm;
      e.an = 4'hF;
      e.dig = 4'h0;
      e.dot = 1'b0;
      e.fd  = 1'b0;
      e.chk_data = 1'b0;
      if (pos == 0) begin
         e.fd = (slot > 0) && (slot % D == 0);
      end else begin
         k = slot % D;
         f = slot / D;
         bound = f * FRAME - 1;
         val = 16'h0;
         dt  = 4'h0;
         foreach (loads[i]) begin
            if (loads[i].m < bound) begin
               val = loads[i].v;
               dt  = loads[i].d;
            end
         end
         up    = val >> (4 * k);
         e.dig = up[3:0];
         e.dot = dt[k];
         e.an[k] = 1'b0;
         e.chk_data = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
         if (k > 0 && up == 16'h0 && !dt[k]) e.an = 4'hF;
`endif
      end
      return e;
   endfunction

   // Monitor: compares each registered output cycle against the queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk($sformatf("an@m%0d", e.m), int'(an), int'(e.an));
         chk($sformatf("frame_done@m%0d", e.m), int'(frame_done), int'(e.fd));
         if (e.chk_data) begin
            chk($sformatf("digit_in@m%0d", e.m), int'(digit_in), int'(e.dig));
            chk($sformatf("dot_out@m%0d", e.m), int'(dot_out), int'(e.dot));
         end
      end
   end

   task automatic run_cycle(input bit ld, input logic [15:0] v, input logic [3:0] d);
      load_t l;
      load  = ld;
      value = v;
      dots  = d;
      if (ld) begin
         l.m = m;
         l.v = v;
         l.d = d;
         loads.push_back(l);
      end
      @(posedge clk);
      #1;
      sbq.push_back(model(m));
      m++;
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b0, 16'h0, 4'h0);
   endtask

   task automatic run_until(input int phase);
      int guard;
      guard = 0;
      while ((m % FRAME) != phase && guard < 2 * FRAME) begin
         run_cycle(1'b0, 16'h0, 4'h0);
         guard++;
      end
   endtask

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
         bit          ld;
         logic [15:0] v;
         logic [3:0]  d;
         ld = ($urandom_range(0, 7) == 0);
         v  = 16'($urandom);
         v  = v >> (4 * $urandom_range(0, 3));
         d  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         run_cycle(ld, v, d);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m        = 0;
      rst_n    = 1'b0;
      load     = 1'b0;
      value    = 16'h0;
      dots     = 4'h0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      chk("reset_an", int'(an), 4'hF);
      chk("reset_digit_in", int'(digit_in), 0);
      chk("reset_dot_out", int'(dot_out), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      rst_n = 1'b1;
      m = 0;

      // Scan order with a fixed value
      idle(2);
      run_cycle(1'b1, 16'h3A7C, 4'b0100);
      idle(3 * FRAME);

      // Load while digit 2 is lit: current frame keeps the old value
      run_until(12);
      run_cycle(1'b1, 16'h1111, 4'h0);
      idle(2 * FRAME);

      // Pending value, then a second load exactly on the boundary cycle
      run_until(5);
      run_cycle(1'b1, 16'h2222, 4'h0);
      run_until(FRAME - 1);
      run_cycle(1'b1, 16'h5555, 4'h0);
      idle(3 * FRAME);

      // Leading zero pattern
      run_cycle(1'b1, 16'h0050, 4'h0);
      idle(3 * FRAME);

      random_phase(300);

      // Asynchronous reset during the digit-1 slot
      run_until(7);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_an", int'(an), 4'hF);
      chk("async_reset_digit_in", int'(digit_in), 0);
      chk("async_reset_frame_done", int'(frame_done), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m = 0;
      loads.delete();
      idle(3 * FRAME);

      random_phase(200);

      @(negedge clk);
      #1;
      chk("scoreboard_drain", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
